// File: rtl/aurora64b66b_rx_checker.sv
// Receive-side incrementing-byte pattern checker for one Aurora 64b66b AXIS RX channel.
// Optional packet-length checking: define AURORA64B66B_RX_CHECKER_LEN_CHECK_EN.
module aurora64b66b_rx_checker #(
    parameter int unsigned DATA_BYTES = 16,
    parameter int unsigned PACK_LEN   = 16,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                    reset,
    input  logic                    clk,
    input  logic [8*DATA_BYTES-1:0] rx_tdata,
    input  logic [DATA_BYTES-1:0]   rx_tkeep,
    input  logic                    rx_tvalid,
    input  logic                    rx_tlast,
    input  logic                    clear,
    output logic                    busy,
    output logic                    pkt_done,
    output logic                    pkt_ok,
    output logic                    beat_err,
    output logic                    err_seen,
    output logic [CNT_WIDTH-1:0]    pkt_cnt,
    output logic [CNT_WIDTH-1:0]    err_cnt
);

    typedef enum logic {S_IDLE, S_PKT} state_t;

    state_t               state, state_d;
    logic [7:0]           exp_byte, exp_byte_d;
    logic                 pkt_err, pkt_err_d;
    logic                 busy_d, pkt_done_d, pkt_ok_d, beat_err_d, err_seen_d;
    logic [CNT_WIDTH-1:0] pkt_cnt_d, err_cnt_d;
    logic                 pat_bad, len_bad, bad;

    if (PACK_LEN < 1 || PACK_LEN > 65535) begin : g_bad_pack_len
        $error("PACK_LEN must be in 1..65535");
    end

    assign pat_bad = (rx_tdata != {DATA_BYTES{exp_byte}}) || (rx_tkeep != '1);

`ifdef AURORA64B66B_RX_CHECKER_LEN_CHECK_EN
    logic [15:0] beat_cnt, beat_cnt_d;
    logic [16:0] beat_num;

    // 1-based number of the current beat; 17 bits so a saturated count never aliases PACK_LEN
    assign beat_num = {1'b0, beat_cnt} + 17'd1;
    assign len_bad  = rx_tlast ? (beat_num != 17'(PACK_LEN)) : (beat_num > 17'(PACK_LEN));

    always_comb begin
        beat_cnt_d = beat_cnt;
        if (rx_tvalid) begin
            if (rx_tlast)
                beat_cnt_d = '0;
            else if (beat_cnt != '1)
                beat_cnt_d = beat_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            beat_cnt <= '0;
        else
            beat_cnt <= beat_cnt_d;
    end
`else
    assign len_bad = 1'b0;
`endif

    assign bad = pat_bad || len_bad;

    always_comb begin
        state_d    = state;
        exp_byte_d = exp_byte;
        pkt_err_d  = pkt_err;
        busy_d     = 1'b0;
        pkt_done_d = 1'b0;
        pkt_ok_d   = 1'b0;
        beat_err_d = 1'b0;
        err_seen_d = err_seen;
        pkt_cnt_d  = pkt_cnt;
        err_cnt_d  = err_cnt;

        if (rx_tvalid) begin
            beat_err_d = bad;
            if (bad)
                err_seen_d = 1'b1;
            if (rx_tlast) begin
                state_d    = S_IDLE;
                exp_byte_d = '0;
                pkt_err_d  = 1'b0;
                pkt_done_d = 1'b1;
                pkt_ok_d   = !(pkt_err || bad);
                if (pkt_cnt != '1)
                    pkt_cnt_d = pkt_cnt + CNT_WIDTH'(1);
                if ((pkt_err || bad) && (err_cnt != '1))
                    err_cnt_d = err_cnt + CNT_WIDTH'(1);
            end else begin
                state_d    = S_PKT;
                exp_byte_d = exp_byte + 8'd1;
                pkt_err_d  = pkt_err || bad;
            end
        end

        // clear wins over same-cycle increments; the completion pulses above are unaffected
        if (clear) begin
            err_seen_d = 1'b0;
            pkt_cnt_d  = '0;
            err_cnt_d  = '0;
        end

        busy_d = (state_d == S_PKT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            exp_byte <= '0;
            pkt_err  <= 1'b0;
            busy     <= 1'b0;
            pkt_done <= 1'b0;
            pkt_ok   <= 1'b0;
            beat_err <= 1'b0;
            err_seen <= 1'b0;
            pkt_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            state    <= state_d;
            exp_byte <= exp_byte_d;
            pkt_err  <= pkt_err_d;
            busy     <= busy_d;
            pkt_done <= pkt_done_d;
            pkt_ok   <= pkt_ok_d;
            beat_err <= beat_err_d;
            err_seen <= err_seen_d;
            pkt_cnt  <= pkt_cnt_d;
            err_cnt  <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_aurora64b66b_rx_checker.sv
// Self-checking bench for aurora64b66b_rx_checker: vector table, corner sequences, random traffic vs packet-level model.
module tb_aurora64b66b_rx_checker;

    localparam int unsigned DB   = 16;
    localparam int unsigned PL   = 16;
    localparam int unsigned CW   = 4;
    localparam longint      CMAX = (64'd1 << CW) - 1;
`ifdef AURORA64B66B_RX_CHECKER_LEN_CHECK_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [8*DB-1:0] rx_tdata = '0;
    logic [DB-1:0]   rx_tkeep = '0;
    logic            rx_tvalid = 1'b0;
    logic            rx_tlast = 1'b0;
    logic            clear = 1'b0;
    logic            busy, pkt_done, pkt_ok, beat_err, err_seen;
    logic [CW-1:0]   pkt_cnt, err_cnt;

    aurora64b66b_rx_checker #(.DATA_BYTES(DB), .PACK_LEN(PL), .CNT_WIDTH(CW)) dut (
        .reset(reset), .clk(clk), .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep),
        .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .clear(clear),
        .busy(busy), .pkt_done(pkt_done), .pkt_ok(pkt_ok), .beat_err(beat_err),
        .err_seen(err_seen), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_seen = 0;

    // packet-level reference: index within packet, packet error flag, predicted outputs
    int     m_idx;
    bit     m_err;
    bit     e_busy, e_done, e_ok, e_berr, e_seen;
    longint e_pkt, e_err;

    typedef struct {
        bit              v;
        logic [8*DB-1:0] d;
        logic [DB-1:0]   k;
        bit              l;
        bit              x_berr;
        bit              x_done;
        bit              x_ok;
        bit              x_busy;
    } vec_t;
    vec_t tbl[48];

    function automatic logic [8*DB-1:0] pat(input int idx);
        logic [7:0] b;
        b = idx[7:0];
        return {DB{b}};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_idx = 0; m_err = 0;
        e_busy = 0; e_done = 0; e_ok = 0; e_berr = 0; e_seen = 0;
        e_pkt = 0; e_err = 0;
    endtask

    task automatic model(input bit v, input logic [8*DB-1:0] d, input logic [DB-1:0] k,
                         input bit l, input bit clr);
        bit bad;
        e_berr = 0; e_done = 0; e_ok = 0;
        if (v) begin
            bad = (d !== pat(m_idx)) || (k !== {DB{1'b1}});
            if (LEN_EN && l && (m_idx + 1 != int'(PL))) bad = 1;
            if (LEN_EN && !l && (m_idx + 1 > int'(PL))) bad = 1;
            e_berr = bad;
            if (bad) e_seen = 1;
            if (l) begin
                e_done = 1;
                e_ok   = !(m_err || bad);
                if (e_pkt < CMAX) e_pkt++;
                if ((m_err || bad) && e_err < CMAX) e_err++;
                m_idx = 0; m_err = 0; e_busy = 0;
            end else begin
                m_idx++;
                m_err  = m_err || bad;
                e_busy = 1;
            end
        end
        if (clr) begin
            e_pkt = 0; e_err = 0; e_seen = 0;
        end
    endtask

    task automatic check_model();
        chk("busy", 64'(busy), 64'(e_busy));
        chk("pkt_done", 64'(pkt_done), 64'(e_done));
        chk("pkt_ok", 64'(pkt_ok), 64'(e_ok));
        chk("beat_err", 64'(beat_err), 64'(e_berr));
        chk("err_seen", 64'(err_seen), 64'(e_seen));
        chk("pkt_cnt", 64'(pkt_cnt), 64'(e_pkt));
        chk("err_cnt", 64'(err_cnt), 64'(e_err));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_pkt_done"}, 64'(pkt_done), 64'd0);
        chk({tag, "_pkt_ok"}, 64'(pkt_ok), 64'd0);
        chk({tag, "_beat_err"}, 64'(beat_err), 64'd0);
        chk({tag, "_err_seen"}, 64'(err_seen), 64'd0);
        chk({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'd0);
        chk({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
    endtask

    // drive one cycle, advance the model, sample just after the edge
    task automatic cycle(input bit v, input logic [8*DB-1:0] d, input logic [DB-1:0] k,
                         input bit l, input bit clr);
        rx_tvalid = v; rx_tdata = d; rx_tkeep = k; rx_tlast = l; clear = clr;
        model(v, d, k, l, clr);
        @(posedge clk);
        #1;
        cyc++;
        if (pkt_done === 1'b1) done_seen++;
        check_model();
    endtask

    task automatic idle();
        cycle(1'b0, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic send_pkt(input int len, input int gap_at, input bit clr_last, output bit ok_out);
        for (int i = 0; i < len; i++) begin
            if (i == gap_at) begin
                idle();
                idle();
            end
            cycle(1'b1, pat(i), '1, i == len - 1, clr_last && (i == len - 1));
        end
        ok_out = pkt_ok;
    endtask

    initial begin
        bit ok;
        bit v, l, clr;
        logic [8*DB-1:0] d;
        logic [DB-1:0] k;
        int tl;
        int bit_idx;

        // vectors: good packet, packet with bad beat 5, packet with partial last beat
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 16; i++) begin
                tbl[p*16+i].v      = 1'b1;
                tbl[p*16+i].d      = pat(i);
                tbl[p*16+i].k      = 16'hFFFF;
                tbl[p*16+i].l      = (i == 15);
                tbl[p*16+i].x_berr = 1'b0;
                tbl[p*16+i].x_done = (i == 15);
                tbl[p*16+i].x_ok   = (i == 15) && (p == 0);
                tbl[p*16+i].x_busy = (i != 15);
            end
        end
        tbl[16+5].d      = {16{8'hAA}};
        tbl[16+5].x_berr = 1'b1;
        tbl[32+15].k     = 16'h00FF;
        tbl[32+15].x_berr = 1'b1;

        model_reset();
        @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        for (int n = 0; n < 48; n++) begin
            cycle(tbl[n].v, tbl[n].d, tbl[n].k, tbl[n].l, 1'b0);
            chk("tbl_beat_err", 64'(beat_err), 64'(tbl[n].x_berr));
            chk("tbl_pkt_done", 64'(pkt_done), 64'(tbl[n].x_done));
            chk("tbl_pkt_ok", 64'(pkt_ok), 64'(tbl[n].x_ok));
            chk("tbl_busy", 64'(busy), 64'(tbl[n].x_busy));
            if (n == 15) begin
                chk("tbl_pkt_cnt_1", 64'(pkt_cnt), 64'd1);
                chk("tbl_err_cnt_0", 64'(err_cnt), 64'd0);
                chk("tbl_err_seen_0", 64'(err_seen), 64'd0);
            end
        end
        chk("tbl_pkt_cnt", 64'(pkt_cnt), 64'd3);
        chk("tbl_err_cnt", 64'(err_cnt), 64'd2);
        chk("tbl_err_seen", 64'(err_seen), 64'd1);

        // short and long packets: faulted only when length checking is built in
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        send_pkt(15, -1, 1'b0, ok);
        chk("len15_ok", 64'(ok), 64'(!LEN_EN));
        send_pkt(17, -1, 1'b0, ok);
        chk("len17_ok", 64'(ok), 64'(!LEN_EN));
        chk("len_err_cnt", 64'(err_cnt), LEN_EN ? 64'd2 : 64'd0);
        chk("len_pkt_cnt", 64'(pkt_cnt), 64'd2);

        // single-beat packet and a 300-beat packet wrapping the expected byte
        send_pkt(1, -1, 1'b0, ok);
        chk("len1_ok", 64'(ok), 64'(!LEN_EN || PL == 1));
        send_pkt(300, -1, 1'b0, ok);
        chk("len300_ok", 64'(ok), 64'(!LEN_EN));

        // back-to-back packets, gaps inside the first, clear on its tlast
        done_seen = 0;
        send_pkt(16, 4, 1'b1, ok);
        chk("b2b_first_ok", 64'(ok), 64'd1);
        chk("b2b_clr_pkt_cnt", 64'(pkt_cnt), 64'd0);
        send_pkt(16, -1, 1'b0, ok);
        chk("b2b_done_pulses", 64'(done_seen), 64'd2);
        chk("b2b_pkt_cnt", 64'(pkt_cnt), 64'd1);

        // reset asserted at beat 8 of a packet
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        cycle(1'b1, {16{8'h55}}, '1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, pat(i), '1, 1'b0, 1'b0);
        rx_tvalid = 1'b1; rx_tdata = pat(8); rx_tkeep = '1; rx_tlast = 1'b0;
        reset = 1'b1;
        #1;
        check_all_zero("rst_async");
        @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        reset = 1'b0;
        model_reset();
        send_pkt(16, -1, 1'b0, ok);
        chk("rst_pkt_ok", 64'(ok), 64'd1);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd1);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);

        // random traffic: gaps, corrupted bits, partial keeps, mixed lengths, rare clears
        tl = $urandom_range(14, 18);
        for (int c = 0; c < 4000; c++) begin
            v   = ($urandom_range(0, 3) != 0);
            d   = pat(m_idx);
            k   = '1;
            if ($urandom_range(0, 19) == 0) begin
                bit_idx = $urandom_range(0, 8*DB-1);
                d[bit_idx] = ~d[bit_idx];
            end
            if ($urandom_range(0, 29) == 0) k = 16'($urandom);
            l   = (m_idx + 1 >= tl);
            clr = ($urandom_range(0, 299) == 0);
            if (!v) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                k = 16'($urandom);
                l = 1'($urandom);
            end
            cycle(v, d, k, l, clr);
            if (v && l) tl = $urandom_range(1, 20);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
